dice_roll_source: RTL and testbench

Upstream feeder for the 4-bit parallel-load display shift register. It synchronises and debounces a raw push-button and free-runs a 1..6 face counter while the button is held. On release it freezes the face, encodes it as a 4-bit pip-group word, and offers that word to the downstream register with a valid/ready handshake. It also keeps a saturating count of completed rolls.

---
 rtl/dice_roll_source.sv | 224 ++++++++++++++++++++++
 tb/tb_dice_roll_source.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_source.sv
// -----------------------------------------------------------------------------
// dice_roll_source
//
// Upstream feeder for a 4-bit parallel-load display shift register.
// A raw push-button is synchronised and debounced. While the button is held,
// a 1..6 face counter free-runs. On release the face freezes, is encoded as a
// 4-bit pip-group word, and is offered downstream with a valid/ready
// handshake. A saturating count of completed rolls is kept.
//
// Handshake: pat_valid is a registered output. Once raised it stays high, and
// pat_word stays stable, until a cycle in which pat_ready is also high. The
// transfer happens on that rising edge and pat_valid drops after it.
// pat_ready never feeds pat_valid combinationally.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive differing synchronised samples needed to
//                     accept a new button level (2..255)
//   CNT_W           : debounce counter width; must hold DEBOUNCE_CYCLES
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   btn_in     in   raw, asynchronous, bouncy button (active high)
//   pat_ready  in   downstream accepts pat_word this cycle
//   pat_valid  out  pat_word holds a new roll result
//   pat_word   out  pip groups {D,C,B,A}, combinational from face
//   face       out  current face, 1..6
//   rolling    out  high while in ROLLING
//   roll_count out  completed rolls, saturating at 255
//   state_dbg  out  FSM state (0 IDLE, 1 ROLLING, 2 PRESENT)
// -----------------------------------------------------------------------------
module dice_roll_source #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       pat_ready,
  output logic       pat_valid,
  output logic [3:0] pat_word,
  output logic [2:0] face,
  output logic       rolling,
  output logic [7:0] roll_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROLLING = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic btn_s;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
  end

  assign btn_s = sync2_q;

  // ---------------------------------------------------------------------------
  // Debounce
  // The counter runs only while the synchronised level disagrees with the
  // accepted level. The edge on which it sits at DEBOUNCE_CYCLES-1 and still
  // disagrees is the one that flips btn_db.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             btn_db_q, btn_db_d;
  logic             btn_db_prev_q, btn_db_prev_d;
  logic             press;
  logic             btn_release;

  always_comb begin
    db_cnt_d      = '0;
    btn_db_d      = btn_db_q;
    btn_db_prev_d = btn_db_q;
    if (btn_s != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  // One-cycle pulses, visible in the cycle after btn_db changes.
  assign press       =  btn_db_q & ~btn_db_prev_q;
  assign btn_release = ~btn_db_q &  btn_db_prev_q;

  // ---------------------------------------------------------------------------
  // Face helpers
  // ---------------------------------------------------------------------------
  // Illegal faces (0, 7) recover to 1 on the next advance.
  function automatic logic [2:0] face_next(input logic [2:0] f);
    logic [2:0] n;
    case (f)
      3'd1:    n = 3'd2;
      3'd2:    n = 3'd3;
      3'd3:    n = 3'd4;
      3'd4:    n = 3'd5;
      3'd5:    n = 3'd6;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  // Pip groups {D,C,B,A}: A centre pip, B one diagonal pair, C the other
  // diagonal pair, D the middle-row pair.
  function automatic logic [3:0] face_encode(input logic [2:0] f);
    logic [3:0] w;
    case (f)
      3'd1:    w = 4'b0001;
      3'd2:    w = 4'b0010;
      3'd3:    w = 4'b0011;
      3'd4:    w = 4'b0110;
      3'd5:    w = 4'b0111;
      3'd6:    w = 4'b1110;
      default: w = 4'b0000;
    endcase
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Roll FSM
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [2:0] face_q, face_d;
  logic       pat_valid_q, pat_valid_d;
  logic       rolling_q, rolling_d;
  logic [7:0] roll_count_q, roll_count_d;

  always_comb begin
    state_d      = state_q;
    face_d       = face_q;
    pat_valid_d  = pat_valid_q;
    rolling_d    = rolling_q;
    roll_count_d = roll_count_q;
    case (state_q)
      ST_IDLE: begin
        // A release seen here is simply ignored.
        if (press) begin
          state_d   = ST_ROLLING;
          rolling_d = 1'b1;
        end
      end
      ST_ROLLING: begin
        // The face freezes on the release edge itself, so the value shown
        // during ROLLING's last cycle is the one presented.
        if (btn_release) begin
          state_d     = ST_PRESENT;
          rolling_d   = 1'b0;
          pat_valid_d = 1'b1;
        end else begin
          face_d = face_next(face_q);
        end
      end
      ST_PRESENT: begin
        // Presses here are dropped: no pending flag is kept.
        if (pat_valid_q && pat_ready) begin
          state_d     = ST_IDLE;
          pat_valid_d = 1'b0;
          if (roll_count_q != 8'hFF) begin
            roll_count_d = roll_count_q + 8'd1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rolling_d   = 1'b0;
        pat_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      state_q       <= ST_IDLE;
      face_q        <= 3'd1;
      pat_valid_q   <= 1'b0;
      rolling_q     <= 1'b0;
      roll_count_q  <= 8'd0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_prev_d;
      state_q       <= state_d;
      face_q        <= face_d;
      pat_valid_q   <= pat_valid_d;
      rolling_q     <= rolling_d;
      roll_count_q  <= roll_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pat_valid  = pat_valid_q;
  assign pat_word   = face_encode(face_q);
  assign face       = face_q;
  assign rolling    = rolling_q;
  assign roll_count = roll_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_dice_roll_source.sv
// -----------------------------------------------------------------------------
// tb_dice_roll_source
//
// Directed bench for dice_roll_source with DEBOUNCE_CYCLES = 16. Inputs are
// driven on the falling clock edge and outputs are sampled there too. Expected
// faces follow from the hold length: a hold of H cycles gives H-1 advances.
// -----------------------------------------------------------------------------
module tb_dice_roll_source;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       pat_ready = 1'b1;
  logic       pat_valid;
  logic [3:0] pat_word;
  logic [2:0] face;
  logic       rolling;
  logic [7:0] roll_count;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  dice_roll_source #(
    .DEBOUNCE_CYCLES(16),
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .pat_ready (pat_ready),
    .pat_valid (pat_valid),
    .pat_word  (pat_word),
    .face      (face),
    .rolling   (rolling),
    .roll_count(roll_count),
    .state_dbg (state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the button for 'hold' sampled edges, release, then follow the
  // handshake. pat_ready is held low for the first ready_wait valid cycles.
  task automatic do_roll(input string tag, input int hold, input int ready_wait,
                         output int vcycles, output logic [3:0] word,
                         output int lat, output logic stable);
    logic seen;
    seen    = 1'b0;
    vcycles = 0;
    lat     = 0;
    word    = 4'h0;
    stable  = 1'b1;
    pat_ready = (ready_wait == 0);
    @(negedge clk);
    btn_in = 1'b1;
    repeat (hold) @(negedge clk);
    btn_in = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (pat_valid) begin
        if (!seen) begin
          seen = 1'b1;
          lat  = i;
          word = pat_word;
        end else if (pat_word !== word) begin
          stable = 1'b0;
        end
        vcycles++;
        if (vcycles > ready_wait) pat_ready = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  int         tgt  [7] = '{1, 2, 3, 4, 5, 6, 1};
  logic [3:0] wexp [7] = '{4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1110, 4'b0001};

  initial begin
    int         vc;
    int         lat;
    logic [3:0] w;
    logic       st;
    logic       any_roll;
    logic       any_valid;
    logic       hold_ok;
    int         f;
    int         a;

    // ---------------- reset ----------------
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pat_valid", 32'(pat_valid), 32'd0);
    chk("rst_face", 32'(face), 32'd1);
    chk("rst_pat_word", 32'(pat_word), 32'b0001);
    chk("rst_rolling", 32'(rolling), 32'd0);
    chk("rst_roll_count", 32'(roll_count), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- bounce: 5-cycle pulses for 100 cycles ----------------
    any_roll  = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      btn_in = ((i / 5) % 2 == 0);
      @(negedge clk);
      any_roll  |= rolling;
      any_valid |= pat_valid;
    end
    btn_in = 1'b0;
    repeat (25) begin
      @(negedge clk);
      any_roll  |= rolling;
      any_valid |= pat_valid;
    end
    chk("bounce_rolling", 32'(any_roll), 32'd0);
    chk("bounce_valid", 32'(any_valid), 32'd0);
    chk("bounce_count", 32'(roll_count), 32'd0);

    // ---------------- basic roll: hold 40 ----------------
    // 39 advances from face 1 -> face 4 -> 0110.
    pat_ready = 1'b1;
    @(negedge clk);
    btn_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 18) chk("t1_rolling_at18", 32'(rolling), 32'd0);
      if (k == 19) chk("t1_rolling_at19", 32'(rolling), 32'd1);
    end
    btn_in = 1'b0;
    lat = 0;
    vc  = 0;
    w   = 4'h0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (pat_valid) begin
        if (vc == 0) begin
          lat = i;
          w   = pat_word;
          chk("t1_face", 32'(face), 32'd4);
          chk("t1_state_present", 32'(state_dbg), 32'd2);
        end
        vc++;
      end else if (vc != 0) begin
        break;
      end
    end
    chk("t1_valid_latency", 32'(lat), 32'd19);
    chk("t1_valid_cycles", 32'(vc), 32'd1);
    chk("t1_word", 32'(w), 32'b0110);
    chk("t1_count", 32'(roll_count), 32'd1);
    chk("t1_state_idle", 32'(state_dbg), 32'd0);

    // ---------------- freeze on each face 1..6, then wrap 6 -> 1 ----------------
    f = 4;
    for (int t = 0; t < 7; t++) begin
      a = (tgt[t] - f + 6) % 6;
      do_roll("t2", 25 + a, 0, vc, w, lat, st);
      chk("t2_word", 32'(w), 32'(wexp[t]));
      chk("t2_face", 32'(face), 32'(tgt[t]));
      chk("t2_vcycles", 32'(vc), 32'd1);
      f = tgt[t];
    end
    chk("t2_count", 32'(roll_count), 32'd8);

    // ---------------- ready held low for 10 cycles ----------------
    // Hold 30 from face 1: 29 advances -> face 6 -> 1110.
    do_roll("t4", 30, 10, vc, w, lat, st);
    chk("t4_vcycles", 32'(vc), 32'd11);
    chk("t4_stable", 32'(st), 32'd1);
    chk("t4_word", 32'(w), 32'b1110);
    chk("t4_count", 32'(roll_count), 32'd9);

    // Second press/release during a long PRESENT is dropped.
    // Hold 30 from face 6: 29 advances -> face 5 -> 0111.
    pat_ready = 1'b0;
    @(negedge clk);
    btn_in = 1'b1;
    repeat (30) @(negedge clk);
    btn_in = 1'b0;
    vc = 0;
    for (int i = 0; i < 60 && !pat_valid; i++) @(negedge clk);
    chk("t4b_valid_up", 32'(pat_valid), 32'd1);
    chk("t4b_word", 32'(pat_word), 32'b0111);
    hold_ok = 1'b1;
    btn_in = 1'b1;
    repeat (22) begin
      @(negedge clk);
      hold_ok &= pat_valid & ~rolling & (pat_word == 4'b0111);
    end
    btn_in = 1'b0;
    repeat (25) begin
      @(negedge clk);
      hold_ok &= pat_valid & ~rolling & (pat_word == 4'b0111);
    end
    chk("t4b_hold_steady", 32'(hold_ok), 32'd1);
    pat_ready = 1'b1;
    @(negedge clk);
    chk("t4b_valid_drop", 32'(pat_valid), 32'd0);
    chk("t4b_count", 32'(roll_count), 32'd10);
    any_roll  = 1'b0;
    any_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      any_roll  |= rolling;
      any_valid |= pat_valid;
    end
    chk("t4b_no_queue_roll", 32'(any_roll), 32'd0);
    chk("t4b_no_queue_valid", 32'(any_valid), 32'd0);
    chk("t4b_count_after", 32'(roll_count), 32'd10);

    // ---------------- reset mid-ROLLING ----------------
    @(negedge clk);
    btn_in = 1'b1;
    repeat (25) @(negedge clk);
    chk("t5_rolling_before", 32'(rolling), 32'd1);
    rst    = 1'b1;
    btn_in = 1'b0;
    #1;
    chk("t5r_rolling", 32'(rolling), 32'd0);
    chk("t5r_valid", 32'(pat_valid), 32'd0);
    chk("t5r_face", 32'(face), 32'd1);
    chk("t5r_word", 32'(pat_word), 32'b0001);
    chk("t5r_count", 32'(roll_count), 32'd0);
    chk("t5r_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    any_roll  = 1'b0;
    any_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      any_roll  |= rolling;
      any_valid |= pat_valid;
    end
    chk("t5r_quiet_roll", 32'(any_roll), 32'd0);
    chk("t5r_quiet_valid", 32'(any_valid), 32'd0);

    // ---------------- reset mid-PRESENT ----------------
    pat_ready = 1'b0;
    @(negedge clk);
    btn_in = 1'b1;
    repeat (25) @(negedge clk);
    btn_in = 1'b0;
    for (int i = 0; i < 60 && !pat_valid; i++) @(negedge clk);
    chk("t5p_valid_up", 32'(pat_valid), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5p_valid", 32'(pat_valid), 32'd0);
    chk("t5p_face", 32'(face), 32'd1);
    chk("t5p_word", 32'(pat_word), 32'b0001);
    chk("t5p_rolling", 32'(rolling), 32'd0);
    chk("t5p_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pat_ready = 1'b1;
    any_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      any_valid |= pat_valid;
    end
    chk("t5p_no_transfer", 32'(any_valid), 32'd0);
    chk("t5p_count", 32'(roll_count), 32'd0);

    // ---------------- saturation over 260 rolls ----------------
    for (int r = 1; r <= 260; r++) begin
      do_roll("t6", 20, 0, vc, w, lat, st);
      chk("t6_count", 32'(roll_count), 32'((r < 255) ? r : 255));
    end
    chk("t6_count_final", 32'(roll_count), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
